// File: rtl/johnson_seq_ctrl_if.sv
// Control/status bundle for the Johnson sequencer.
// master drives requests, slave returns state and decodes.
interface johnson_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int IDX_W = 3
);
  logic             start;
  logic [CNT_W-1:0] run_len;
  logic             dir;
  logic             hold;
  logic             abort;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             err;
  logic [WIDTH-1:0] count;
  logic [2*WIDTH-1:0] phase;
  logic [IDX_W-1:0] phase_idx;

  modport master (
    output start, run_len, dir, hold, abort, load, load_val,
    input  busy, done, aborted, err, count, phase, phase_idx
  );

  modport slave (
    input  start, run_len, dir, hold, abort, load, load_val,
    output busy, done, aborted, err, count, phase, phase_idx
  );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Run-length sequencer for a WIDTH-stage Johnson counter.
// Steps fwd/rev under start/busy/done with pause, abort and checked load.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int IDX_W = 3
) (
  input logic clk,
  input logic reset,
  johnson_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abrt_q, abrt_d;
  logic             err_q, err_d;

  logic [2*WIDTH-1:0] phase;
  logic [IDX_W-1:0]   idx;
  logic               ld_ok;
  logic [WIDTH-1:0]   stepped;

  localparam logic [WIDTH-1:0] SEED = WIDTH'(1);

  // Code for index i: low ones fill first, then low zeros fill.
  function automatic logic [WIDTH-1:0] code_of(input int i);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (i < WIDTH) return ones >> (WIDTH - 1 - i);
    else           return ones << (i - WIDTH + 1);
  endfunction

  always_comb begin
    phase = '0;
    idx   = '0;
    ld_ok = 1'b0;
    for (int i = 0; i < 2*WIDTH; i++) begin
      if (count_q == code_of(i)) begin
        phase[i] = 1'b1;
        idx      = IDX_W'(i);
      end
      if (bus.load_val == code_of(i)) ld_ok = 1'b1;
    end
  end

  assign stepped = bus.dir ?
    {~count_q[0], count_q[WIDTH-1:1]} :
    {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    abrt_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (ld_ok) begin
            count_d = bus.load_val;
          end else begin
            count_d = SEED;
            err_d   = 1'b1;
          end
        end else if (bus.start) begin
          if (bus.run_len == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = bus.run_len;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          abrt_d  = 1'b1;
        end else if (bus.hold) begin
          state_d = PAUSE;
        end else begin
          count_d = stepped;
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (bus.abort) begin
          state_d = IDLE;
          abrt_d  = 1'b1;
        end else if (!bus.hold) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= SEED;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = abrt_q;
  assign bus.err       = err_q;
  assign bus.count     = count_q;
  assign bus.phase     = phase;
  assign bus.phase_idx = idx;

endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
Run-length controller and sequencer for a WIDTH-stage Johnson counter. It steps the internal Johnson register forward or backward for a programmed number of steps under a start/busy/done handshake, and supports pause and abort. It parallel-loads only legal Johnson codes and decodes the current code to a one-hot phase and a binary phase index. It drives multi-phase enables for downstream timing logic.

Parameters:
WIDTH, 4, number of Johnson stages; the sequence has 2*WIDTH states
CNT_W, 8, width of the run-length counter
IDX_W, 3, phase index width; must equal ceil(log2(2*WIDTH))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active high
start  in  1  request a run; sampled in IDLE only
run_len  in  CNT_W  number of steps; latched on an accepted start
dir  in  1  0 = forward {count[W-2:0], ~count[W-1]}; 1 = reverse {~count[0], count[W-1:1]}; sampled on every step
hold  in  1  pause stepping while running
abort  in  1  terminate the current run
load  in  1  parallel load request; honoured in IDLE only
load_val  in  WIDTH  value to load
busy  out  1  high in RUN or PAUSE
done  out  1  one-cycle pulse when a run completes
aborted  out  1  one-cycle pulse when a run is aborted
err  out  1  one-cycle pulse when an illegal load value is rejected
count  out  WIDTH  Johnson register
phase  out  2*WIDTH  one-hot decode of count
phase_idx  out  IDX_W  binary index of count

Behaviour:
- All outputs are registered except phase and phase_idx, which are combinational decodes of count.
- Reset (async): count = 0...01, state = IDLE, remaining = 0, busy/done/aborted/err = 0. Reset mid-run aborts with no pulses.
- Legal codes: 0^(W-k)1^k for k=1..W, mapped to idx k-1; 1^(W-k)0^k for k=1..W, mapped to idx W-1+k. The all-zero code is idx 2W-1. For WIDTH=4: 0001=0, 0011=1, 0111=2, 1111=3, 1110=4, 1100=5, 1000=6, 0000=7.
- FSM states: IDLE, RUN, PAUSE.
- IDLE, priority order:
  - load wins over start; start is ignored in the same cycle.
    - Legal load_val: count <= load_val.
    - Illegal load_val: count <= 0...01 and err pulses for 1 cycle.
  - start with run_len == 0: done pulses on the next cycle, count is unchanged, state stays IDLE.
  - start with run_len > 0: remaining <= run_len, next state RUN, busy = 1 from the next cycle. No step occurs on the accept edge.
- RUN, priority order abort > hold > step:
  - abort: go to IDLE, count holds, aborted pulses, done is not asserted.
  - hold: go to PAUSE; no step on this edge.
  - Otherwise step count per dir and decrement remaining.
  - If remaining == 1 on a step: go to IDLE and assert done on the same edge the final code appears; busy drops on that edge.
- PAUSE: count frozen.
  - abort: go to IDLE with aborted.
  - !hold: go to RUN; no step on this edge; stepping resumes on the next edge.
- Wrap-around is natural: the sequence is modulo 2*WIDTH in either direction. Changing dir mid-run is legal and takes effect on the next step.
- start, load and run_len are ignored while busy. hold and abort are ignored in IDLE.
- done, aborted and err are never asserted together.
- A run of N steps with no hold occupies busy for exactly N cycles.

Test Plan:
1. Assert then release reset -> count=0001, phase=00000001, phase_idx=0, busy=0, done=0, aborted=0, err=0.
2. start, run_len=10, dir=0 from 0001 -> busy for 10 cycles, codes 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001, 0011, 0111. done pulses with final count=0111, idx=2, and busy falls on that edge.
3. start, run_len=3, dir=1 from 0001 -> 0000, 1000, 1100, then done; phase_idx=5. Then start with run_len=0 -> done pulse one cycle later, count stays 1100, busy stays 0.
4. run_len=5, dir=0, hold high for 2 cycles after 2 steps -> count frozen at 0111 for 3 edges, busy high for 8 cycles total, final count=1100, single done pulse.
5. IDLE load 0101 -> count=0001, err pulse. Load 1100 -> count=1100, idx=5, no err. Same-cycle load=1100 and start -> load applied, start ignored, busy stays 0.
6. run_len=8, abort after 4 steps from 0001 -> aborted pulse, count holds 1110, no done. Repeat and assert reset mid-run -> count=0001, busy=0 immediately, no pulses.
